// File: rtl/data_mem_pkg.sv
// rtl/data_mem_pkg.sv - shared sizes, controller states and alignment check for data_mem_ctrl
package data_mem_pkg;

  localparam logic [1:0] SZ_BYTE = 2'd0;
  localparam logic [1:0] SZ_HALF = 2'd1;
  localparam logic [1:0] SZ_WORD = 2'd2;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    BEAT   = 2'd2,
    RESP   = 2'd3
  } state_t;

  // Size 3 is never aligned, so an illegal type also reads as misaligned.
  function automatic logic is_aligned(input logic [1:0] size, input logic [1:0] lane);
    case (size)
      SZ_BYTE: is_aligned = 1'b1;
      SZ_HALF: is_aligned = ~lane[0];
      SZ_WORD: is_aligned = (lane == 2'd0);
      default: is_aligned = 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/data_mem_load_align.sv
// rtl/data_mem_load_align.sv - selects byte/half from a word by lane and sign/zero-extends it
module data_mem_load_align
  import data_mem_pkg::*;
(
  input  logic [31:0] word,
  input  logic [1:0]  lane,
  input  logic [1:0]  size,
  input  logic        is_unsigned,
  output logic [31:0] data
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  always_comb begin
    byte_sel = word[{lane, 3'b000} +: 8];
    half_sel = lane[1] ? word[31:16] : word[15:0];
    case (size)
      SZ_BYTE: data = {{24{byte_sel[7] & ~is_unsigned}}, byte_sel};
      SZ_HALF: data = {{16{half_sel[15] & ~is_unsigned}}, half_sel};
      default: data = word;
    endcase
  end

endmodule

// File: rtl/data_mem_ctrl.sv
// rtl/data_mem_ctrl.sv - two-port round-robin data-memory controller with load alignment
// Misaligned half/word accesses are split into byte beats when MEM_MISALIGN_SPLIT_EN is defined.
module data_mem_ctrl
  import data_mem_pkg::*;
#(
  parameter int ADDR_W = 10
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  input  logic [1:0]             req_valid_i,
  output logic [1:0]             req_ready_o,
  input  logic [1:0]             req_we_i,
  input  logic [1:0][1:0]        req_type_i,
  input  logic [1:0]             req_unsigned_i,
  input  logic [1:0][ADDR_W-1:0] req_addr_i,
  input  logic [1:0][31:0]       req_wdata_i,
  output logic [1:0]             rsp_valid_o,
  output logic [31:0]            rsp_rdata_o,
  output logic                   rsp_err_o,
  output logic                   mem_en_o,
  output logic [ADDR_W-3:0]      mem_word_o,
  output logic [1:0]             mem_type_o,
  output logic [1:0]             mem_lane_o,
  output logic [31:0]            mem_wdata_o,
  input  logic [31:0]            mem_rdata_i
);

  state_t              state, state_nx;
  logic                last_q, gnt_q, gnt_sel, accept;
  logic                we_q, uns_q, err_q;
  logic                sel_misal, sel_illegal;
  logic [1:0]          type_q, sel_type, sel_lane, align_lane;
  logic [ADDR_W-1:0]   addr_q;
  logic [31:0]         wdata_q, rdata_q, load_data;

  // On contention the port not served last wins; otherwise the only valid port.
  assign gnt_sel     = (&req_valid_i) ? ~last_q : req_valid_i[1];
  assign accept      = ~rst_i && (state == IDLE) && (|req_valid_i);
  assign sel_type    = req_type_i[gnt_sel];
  assign sel_lane    = req_addr_i[gnt_sel][1:0];
  assign sel_illegal = (sel_type == 2'd3);
  assign sel_misal   = ~is_aligned(sel_type, sel_lane);

`ifdef MEM_MISALIGN_SPLIT_EN
  logic              split_q, last_beat;
  logic [1:0]        beat_q;
  logic [ADDR_W-1:0] beat_addr;

  assign beat_addr  = addr_q + ADDR_W'(beat_q);
  assign last_beat  = (beat_q == ((type_q == SZ_HALF) ? 2'd1 : 2'd3));
  // Split loads are assembled little-endian from bit 0, so extend as if lane 0.
  assign align_lane = split_q ? 2'd0 : addr_q[1:0];
`else
  assign align_lane = addr_q[1:0];
`endif

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state   <= IDLE;
      last_q  <= 1'b1;
      gnt_q   <= 1'b0;
      we_q    <= 1'b0;
      uns_q   <= 1'b0;
      err_q   <= 1'b0;
      type_q  <= 2'd0;
      addr_q  <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
`ifdef MEM_MISALIGN_SPLIT_EN
      split_q <= 1'b0;
      beat_q  <= 2'd0;
`endif
    end else begin
      state <= state_nx;
      if (accept) begin
        gnt_q   <= gnt_sel;
        we_q    <= req_we_i[gnt_sel];
        uns_q   <= req_unsigned_i[gnt_sel];
        type_q  <= sel_type;
        addr_q  <= req_addr_i[gnt_sel];
        wdata_q <= req_wdata_i[gnt_sel];
`ifdef MEM_MISALIGN_SPLIT_EN
        err_q   <= sel_illegal;
        split_q <= sel_misal & ~sel_illegal;
        beat_q  <= 2'd0;
`else
        err_q   <= sel_misal;
`endif
      end
      if (state == ACCESS) rdata_q <= mem_rdata_i;
`ifdef MEM_MISALIGN_SPLIT_EN
      if (state == BEAT) begin
        beat_q <= beat_q + 2'd1;
        rdata_q[{beat_q, 3'b000} +: 8] <= mem_rdata_i[{beat_addr[1:0], 3'b000} +: 8];
      end
`endif
      if (state == RESP) last_q <= gnt_q;
    end
  end

  always_comb begin
    state_nx    = state;
    req_ready_o = 2'b00;
    rsp_valid_o = 2'b00;
    rsp_rdata_o = '0;
    rsp_err_o   = 1'b0;
    mem_en_o    = 1'b0;
    mem_word_o  = '0;
    mem_type_o  = 2'd0;
    mem_lane_o  = 2'd0;
    mem_wdata_o = '0;
    case (state)
      IDLE: begin
        if (accept) begin
          req_ready_o = gnt_sel ? 2'b10 : 2'b01;
`ifdef MEM_MISALIGN_SPLIT_EN
          state_nx = (sel_misal & ~sel_illegal) ? BEAT : ACCESS;
`else
          state_nx = ACCESS;
`endif
        end
      end
      ACCESS: begin
        mem_en_o    = we_q & ~err_q;
        mem_word_o  = addr_q[ADDR_W-1:2];
        mem_lane_o  = addr_q[1:0];
        mem_type_o  = type_q;
        mem_wdata_o = wdata_q;
        state_nx    = RESP;
      end
`ifdef MEM_MISALIGN_SPLIT_EN
      BEAT: begin
        mem_en_o    = we_q;
        mem_word_o  = beat_addr[ADDR_W-1:2];
        mem_lane_o  = beat_addr[1:0];
        mem_type_o  = SZ_BYTE;
        mem_wdata_o = {24'd0, wdata_q[{beat_q, 3'b000} +: 8]};
        if (last_beat) state_nx = RESP;
      end
`endif
      RESP: begin
        rsp_valid_o = gnt_q ? 2'b10 : 2'b01;
        rsp_err_o   = err_q;
        rsp_rdata_o = (we_q | err_q) ? 32'd0 : load_data;
        state_nx    = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  data_mem_load_align u_load_align (
    .word        (rdata_q),
    .lane        (align_lane),
    .size        (type_q),
    .is_unsigned (uns_q),
    .data        (load_data)
  );

endmodule

// File: tb/tb_data_mem_ctrl.sv
// tb/tb_data_mem_ctrl.sv - scoreboard bench for data_mem_ctrl (both MEM_MISALIGN_SPLIT_EN builds)
module tb_data_mem_ctrl;

  logic             clk = 1'b0;
  logic             rst_i;
  logic [1:0]       req_valid, req_we, req_uns;
  logic [1:0][1:0]  req_type;
  logic [1:0][9:0]  req_addr;
  logic [1:0][31:0] req_wdata;
  logic [1:0]       req_ready_o, rsp_valid_o;
  logic [31:0]      rsp_rdata_o, mem_wdata_o, mem_rdata_i;
  logic             rsp_err_o, mem_en_o;
  logic [7:0]       mem_word_o;
  logic [1:0]       mem_type_o, mem_lane_o;
  logic [31:0]      mem [256];

  always #5 clk = ~clk;

  data_mem_ctrl #(.ADDR_W(10)) dut (
    .clk_i(clk), .rst_i(rst_i),
    .req_valid_i(req_valid), .req_ready_o(req_ready_o), .req_we_i(req_we),
    .req_type_i(req_type), .req_unsigned_i(req_uns), .req_addr_i(req_addr),
    .req_wdata_i(req_wdata), .rsp_valid_o(rsp_valid_o), .rsp_rdata_o(rsp_rdata_o),
    .rsp_err_o(rsp_err_o), .mem_en_o(mem_en_o), .mem_word_o(mem_word_o),
    .mem_type_o(mem_type_o), .mem_lane_o(mem_lane_o), .mem_wdata_o(mem_wdata_o),
    .mem_rdata_i(mem_rdata_i)
  );

  // Byte-lane array behind the controller.
  assign mem_rdata_i = mem[mem_word_o];
  always @(posedge clk) begin
    if (mem_en_o) begin
      case (mem_type_o)
        2'd0:    mem[mem_word_o][{mem_lane_o, 3'b000} +: 8] <= mem_wdata_o[7:0];
        2'd1:    mem[mem_word_o][{mem_lane_o[1], 4'b0000} +: 16] <= mem_wdata_o[15:0];
        default: mem[mem_word_o] <= mem_wdata_o;
      endcase
    end
  end

  typedef struct {
    logic [1:0]  port;
    logic [31:0] data;
    logic        err;
    int          lat;
  } exp_t;

  exp_t exp_q[$];
  int   n_checks = 0;
  int   n_fail = 0;

  // Observations of the most recent access
  bit          acc_ok, rsp_seen;
  int          st_n, rsp_lat;
  int          st_lat [8];
  logic [7:0]  st_word [8];
  logic [1:0]  st_lane [8];
  logic [1:0]  st_type [8];
  logic [31:0] st_wdata [8];
  logic [1:0]  rsp_vec;
  logic [31:0] rsp_data;
  logic        rsp_e;

  task automatic access(input int p, input logic we, input logic [1:0] ty, input logic uns,
                        input logic [9:0] addr, input logic [31:0] wd);
    int n;
    acc_ok = 0; rsp_seen = 0; st_n = 0; n = 0;
    @(negedge clk);
    req_we[p] = we; req_type[p] = ty; req_uns[p] = uns;
    req_addr[p] = addr; req_wdata[p] = wd; req_valid[p] = 1'b1;
    for (int i = 0; i < 10 && !acc_ok; i++) begin
      #1;
      if (req_ready_o[p]) acc_ok = 1;
      else @(negedge clk);
    end
    @(posedge clk); #1;
    req_valid[p] = 1'b0;
    while (n < 12 && !rsp_seen) begin
      @(negedge clk);
      n++;
      if (mem_en_o && st_n < 8) begin
        st_lat[st_n] = n; st_word[st_n] = mem_word_o; st_lane[st_n] = mem_lane_o;
        st_type[st_n] = mem_type_o; st_wdata[st_n] = mem_wdata_o; st_n++;
      end
      if (|rsp_valid_o) begin
        rsp_seen = 1; rsp_lat = n; rsp_vec = rsp_valid_o;
        rsp_data = rsp_rdata_o; rsp_e = rsp_err_o;
      end
    end
  endtask

  task automatic test_reset();
    rst_i = 1'b1; req_valid = 2'b11;
    repeat (2) @(negedge clk);
    n_checks++;
    if (req_ready_o !== 2'b00 || rsp_valid_o !== 2'b00 || rsp_err_o !== 1'b0 || mem_en_o !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_ctrl: ready %b rsp %b err %b en %b, want all 0", req_ready_o, rsp_valid_o, rsp_err_o, mem_en_o);
    end
    n_checks++;
    if ({mem_word_o, mem_type_o, mem_lane_o} !== 12'd0) begin
      n_fail++;
      $display("FAIL reset_addr: word %h type %h lane %h, want 0", mem_word_o, mem_type_o, mem_lane_o);
    end
    n_checks++;
    if ({rsp_rdata_o, mem_wdata_o} !== 64'd0) begin
      n_fail++;
      $display("FAIL reset_data: rdata %h wdata %h, want 0", rsp_rdata_o, mem_wdata_o);
    end
    req_valid = 2'b00;
    rst_i = 1'b0;
  endtask

  task automatic test_word_store_load();
    exp_t e;
    exp_q.push_back('{2'b01, 32'h0, 1'b0, 2});
    access(0, 1'b1, 2'd2, 1'b0, 10'h010, 32'hDEADBEEF);
    n_checks++;
    if (st_n != 1 || st_lat[0] != 1 || st_word[0] !== 8'd4 || st_lane[0] !== 2'd0 ||
        st_type[0] !== 2'd2 || st_wdata[0] !== 32'hDEADBEEF) begin
      n_fail++;
      $display("FAIL store_strobe: n %0d lat %0d word %0d lane %0d type %0d wdata %h, want 1 1 4 0 2 deadbeef",
               st_n, st_lat[0], st_word[0], st_lane[0], st_type[0], st_wdata[0]);
    end
    e = exp_q.pop_front();
    n_checks++;
    if (!acc_ok || !rsp_seen || rsp_vec !== e.port || rsp_lat != e.lat || rsp_e !== e.err) begin
      n_fail++;
      $display("FAIL store_rsp: port %b lat %0d err %b, want %b %0d %b", rsp_vec, rsp_lat, rsp_e, e.port, e.lat, e.err);
    end
    exp_q.push_back('{2'b01, 32'hDEADBEEF, 1'b0, 2});
    access(0, 1'b0, 2'd2, 1'b0, 10'h010, 32'h0);
    e = exp_q.pop_front();
    n_checks++;
    if (!acc_ok || !rsp_seen || st_n != 0 || rsp_vec !== e.port || rsp_lat != e.lat ||
        rsp_e !== e.err || rsp_data !== e.data) begin
      n_fail++;
      $display("FAIL word_load: strobes %0d port %b lat %0d err %b data %h, want 0 %b %0d %b %h",
               st_n, rsp_vec, rsp_lat, rsp_e, rsp_data, e.port, e.lat, e.err, e.data);
    end
  endtask

  task automatic test_loads();
    int          t_port [8] = '{0, 0, 0, 0, 1, 0, 1, 0};
    logic        t_we   [8] = '{0, 0, 0, 0, 0, 1, 0, 0};
    logic [1:0]  t_ty   [8] = '{0, 0, 1, 1, 0, 3, 3, 2};
    logic        t_uns  [8] = '{0, 1, 0, 1, 0, 0, 0, 0};
    logic [9:0]  t_addr [8] = '{10'h013, 10'h013, 10'h012, 10'h010, 10'h010, 10'h010, 10'h010, 10'h010};
    logic [31:0] t_exp  [8] = '{32'hFFFFFFDE, 32'h000000DE, 32'hFFFFDEAD, 32'h0000BEEF,
                                32'hFFFFFFEF, 32'h0, 32'h0, 32'hDEADBEEF};
    logic        t_err  [8] = '{0, 0, 0, 0, 0, 1, 1, 0};
    exp_t e;
    for (int i = 0; i < 8; i++) begin
      exp_q.push_back('{t_port[i] == 1 ? 2'b10 : 2'b01, t_exp[i], t_err[i], 2});
      access(t_port[i], t_we[i], t_ty[i], t_uns[i], t_addr[i], 32'h0);
      e = exp_q.pop_front();
      n_checks++;
      if (!acc_ok || !rsp_seen || rsp_vec !== e.port || rsp_lat != e.lat || rsp_e !== e.err ||
          (!e.err && rsp_data !== e.data)) begin
        n_fail++;
        $display("FAIL load_%0d: port %b lat %0d err %b data %h, want %b %0d %b %h",
                 i, rsp_vec, rsp_lat, rsp_e, rsp_data, e.port, e.lat, e.err, e.data);
      end
      n_checks++;
      if (st_n != 0) begin
        n_fail++;
        $display("FAIL load_%0d_strobe: %0d strobes, want 0", i, st_n);
      end
    end
  endtask

  task automatic test_arbitration();
    logic [1:0] g_exp [3] = '{2'b01, 2'b10, 2'b01};
    int         t_acc [3];
    int         gi = 0;
    int         n = 0;
    exp_t       e;
    @(negedge clk); rst_i = 1'b1;
    @(negedge clk); rst_i = 1'b0;
    req_we = 2'b00; req_type[0] = 2'd2; req_uns[0] = 1'b0; req_addr[0] = 10'h010;
    req_type[1] = 2'd0; req_uns[1] = 1'b1; req_addr[1] = 10'h011;
    req_valid = 2'b11;
    while (n < 40 && (gi < 3 || exp_q.size() > 0)) begin
      #1;
      if (|req_ready_o && gi < 3) begin
        n_checks++;
        if (req_ready_o !== g_exp[gi]) begin
          n_fail++;
          $display("FAIL arb_grant_%0d: ready %b, want %b", gi, req_ready_o, g_exp[gi]);
        end
        exp_q.push_back('{g_exp[gi], g_exp[gi][1] ? 32'h000000BE : 32'hDEADBEEF, 1'b0, 0});
        t_acc[gi] = n;
        gi++;
        if (gi == 3) begin
          @(posedge clk); #1;
          req_valid = 2'b00;
        end
      end
      if (|rsp_valid_o) begin
        n_checks++;
        if (exp_q.size() == 0) begin
          n_fail++;
          $display("FAIL arb_rsp: unexpected rsp %b data %h", rsp_valid_o, rsp_rdata_o);
        end else begin
          e = exp_q.pop_front();
          if (rsp_valid_o !== e.port || rsp_err_o !== e.err || rsp_rdata_o !== e.data) begin
            n_fail++;
            $display("FAIL arb_rsp: port %b err %b data %h, want %b %b %h",
                     rsp_valid_o, rsp_err_o, rsp_rdata_o, e.port, e.err, e.data);
          end
        end
      end
      @(negedge clk);
      n++;
    end
    n_checks++;
    if (gi != 3 || exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL arb_timeout: grants %0d pending %0d, want 3 0", gi, exp_q.size());
      exp_q.delete();
    end else begin
      n_checks++;
      if (t_acc[1] - t_acc[0] != 3 || t_acc[2] - t_acc[1] != 3) begin
        n_fail++;
        $display("FAIL arb_interval: %0d %0d, want 3 3", t_acc[1] - t_acc[0], t_acc[2] - t_acc[1]);
      end
    end
  endtask

  task automatic test_misaligned();
`ifdef MEM_MISALIGN_SPLIT_EN
    int         m_n    [4] = '{4, 0, 2, 0};
    logic       m_we   [4] = '{1, 0, 1, 0};
    logic [1:0] m_ty   [4] = '{2, 2, 1, 1};
    logic [9:0] m_addr [4] = '{10'h00D, 10'h00D, 10'h3FF, 10'h3FF};
    logic [31:0] m_wd  [4] = '{32'h11223344, 32'h0, 32'h0000A55A, 32'h0};
    logic [31:0] m_exp [4] = '{32'h0, 32'h11223344, 32'h0, 32'hFFFFA55A};
    int         m_lat  [4] = '{5, 5, 3, 3};
    logic       m_err  [4] = '{0, 0, 0, 0};
    logic [7:0] s_word [6] = '{8'd3, 8'd3, 8'd3, 8'd4, 8'd255, 8'd0};
    logic [1:0] s_lane [6] = '{2'd1, 2'd2, 2'd3, 2'd0, 2'd3, 2'd0};
    logic [7:0] s_byte [6] = '{8'h44, 8'h33, 8'h22, 8'h11, 8'h5A, 8'hA5};
`else
    int         m_n    [4] = '{0, 0, 0, 0};
    logic       m_we   [4] = '{1, 0, 1, 0};
    logic [1:0] m_ty   [4] = '{2, 1, 1, 2};
    logic [9:0] m_addr [4] = '{10'h00D, 10'h001, 10'h3FF, 10'h012};
    logic [31:0] m_wd  [4] = '{32'h11223344, 32'h0, 32'h0000A55A, 32'h0};
    logic [31:0] m_exp [4] = '{32'h0, 32'h0, 32'h0, 32'h0};
    int         m_lat  [4] = '{2, 2, 2, 2};
    logic       m_err  [4] = '{1, 1, 1, 1};
    logic [7:0] s_word [6] = '{8'd0, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0};
    logic [1:0] s_lane [6] = '{2'd0, 2'd0, 2'd0, 2'd0, 2'd0, 2'd0};
    logic [7:0] s_byte [6] = '{8'h0, 8'h0, 8'h0, 8'h0, 8'h0, 8'h0};
`endif
    int   k = 0;
    exp_t e;
    for (int i = 0; i < 4; i++) begin
      exp_q.push_back('{2'b01, m_exp[i], m_err[i], m_lat[i]});
      access(0, m_we[i], m_ty[i], 1'b0, m_addr[i], m_wd[i]);
      n_checks++;
      if (st_n != m_n[i]) begin
        n_fail++;
        $display("FAIL mis_%0d_strobes: %0d, want %0d", i, st_n, m_n[i]);
      end else begin
        for (int j = 0; j < m_n[i]; j++) begin
          n_checks++;
          if (st_lat[j] != j + 1 || st_word[j] !== s_word[k + j] || st_lane[j] !== s_lane[k + j] ||
              st_type[j] !== 2'd0 || st_wdata[j][7:0] !== s_byte[k + j]) begin
            n_fail++;
            $display("FAIL mis_%0d_beat_%0d: lat %0d word %0d lane %0d type %0d byte %h, want %0d %0d %0d 0 %h",
                     i, j, st_lat[j], st_word[j], st_lane[j], st_type[j], st_wdata[j][7:0],
                     j + 1, s_word[k + j], s_lane[k + j], s_byte[k + j]);
          end
        end
      end
      k += m_n[i];
      e = exp_q.pop_front();
      n_checks++;
      if (!acc_ok || !rsp_seen || rsp_vec !== e.port || rsp_lat != e.lat || rsp_e !== e.err ||
          (!e.err && rsp_data !== e.data)) begin
        n_fail++;
        $display("FAIL mis_%0d_rsp: port %b lat %0d err %b data %h, want %b %0d %b %h",
                 i, rsp_vec, rsp_lat, rsp_e, rsp_data, e.port, e.lat, e.err, e.data);
      end
    end
  endtask

  task automatic test_reset_during_access();
    bit   quiet = 1;
    int   n = 0;
    exp_t e;
    @(negedge clk);
    req_we[0] = 1'b1; req_type[0] = 2'd2; req_uns[0] = 1'b0;
    req_addr[0] = 10'h020; req_wdata[0] = 32'hCAFEF00D; req_valid[0] = 1'b1;
    #1;
    n_checks++;
    if (req_ready_o !== 2'b01) begin
      n_fail++;
      $display("FAIL rst_first_accept: ready %b, want 01", req_ready_o);
    end
    @(posedge clk); #1;
    n_checks++;
    if (mem_en_o !== 1'b1) begin
      n_fail++;
      $display("FAIL rst_pre_strobe: en %b, want 1", mem_en_o);
    end
    rst_i = 1'b1;
    #1;
    n_checks++;
    if (mem_en_o !== 1'b0 || req_ready_o !== 2'b00) begin
      n_fail++;
      $display("FAIL rst_drop: en %b ready %b, want 0 00", mem_en_o, req_ready_o);
    end
    repeat (3) begin
      @(negedge clk);
      if (rsp_valid_o !== 2'b00 || mem_en_o !== 1'b0) quiet = 0;
    end
    n_checks++;
    if (!quiet) begin
      n_fail++;
      $display("FAIL rst_quiet: response or strobe seen during reset, want none");
    end
    rst_i = 1'b0;
    #1;
    n_checks++;
    if (req_ready_o !== 2'b01) begin
      n_fail++;
      $display("FAIL rst_reaccept: ready %b, want 01", req_ready_o);
    end
    exp_q.push_back('{2'b01, 32'h0, 1'b0, 2});
    @(posedge clk); #1;
    req_valid[0] = 1'b0;
    rsp_seen = 0; st_n = 0;
    while (n < 8 && !rsp_seen) begin
      @(negedge clk);
      n++;
      if (mem_en_o) st_n++;
      if (|rsp_valid_o) begin
        rsp_seen = 1; rsp_lat = n; rsp_vec = rsp_valid_o; rsp_e = rsp_err_o;
      end
    end
    e = exp_q.pop_front();
    n_checks++;
    if (!rsp_seen || st_n != 1 || rsp_vec !== e.port || rsp_lat != e.lat || rsp_e !== e.err) begin
      n_fail++;
      $display("FAIL rst_retry: seen %0d strobes %0d port %b lat %0d err %b, want 1 1 %b %0d %b",
               rsp_seen, st_n, rsp_vec, rsp_lat, rsp_e, e.port, e.lat, e.err);
    end
    exp_q.push_back('{2'b10, 32'hCAFEF00D, 1'b0, 2});
    access(1, 1'b0, 2'd2, 1'b0, 10'h020, 32'h0);
    e = exp_q.pop_front();
    n_checks++;
    if (!acc_ok || !rsp_seen || rsp_vec !== e.port || rsp_lat != e.lat || rsp_data !== e.data) begin
      n_fail++;
      $display("FAIL rst_readback: port %b lat %0d data %h, want %b %0d %h",
               rsp_vec, rsp_lat, rsp_data, e.port, e.lat, e.data);
    end
  endtask

  initial begin
    rst_i = 1'b1;
    req_valid = '0; req_we = '0; req_uns = '0;
    req_type = '0; req_addr = '0; req_wdata = '0;
    test_reset();
    test_word_store_load();
    test_loads();
    test_arbitration();
    test_misaligned();
    test_reset_during_access();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
